atm_multi_account: RTL and testbench

Parametrised next-generation ATM transaction engine: a register-file account store (balance, PIN, failed-attempt counter per account) behind a start/done request handshake. It executes balance enquiry, withdraw, deposit and PIN change. It adds per-account PIN lockout, deposit overflow protection and a coded error result. It sits between the front-panel input logic and the display/receipt logic.

---
 rtl/atm_multi_account.sv | 199 +++++++++++++++++++
 tb/tb_atm_multi_account.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/atm_multi_account.sv
// ==========================================================================
// Module   : atm_multi_account
// Purpose  : Multi-account ATM transaction engine. Per-account balance, PIN,
//            fail counter and lock bit behind a start/done handshake.
// Revision : 1.0 - initial release
// ==========================================================================
`default_nettype none

module atm_multi_account #(
    parameter int NUM_ACC   = 10,
    parameter int ACC_W     = 4,
    parameter int PIN_W     = 14,
    parameter int BAL_W     = 32,
    parameter int AMT_W     = 16,
    parameter int MAX_TRIES = 3,
    parameter int INIT_BAL  = 5000,
    parameter int INIT_PIN  = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         operation,
    input  logic [ACC_W-1:0]   acc_num,
    input  logic [PIN_W-1:0]   pin,
    input  logic [PIN_W-1:0]   new_pin,
    input  logic [AMT_W-1:0]   amount,
    output logic               busy,
    output logic               done,
    output logic               success,
    output logic [2:0]         err_code,
    output logic [BAL_W-1:0]   balance,
    output logic               locked,
    output logic [2:0]         state
);

    localparam int CNT_W = $clog2(MAX_TRIES + 1);

    localparam logic [2:0] E_OK       = 3'd0;
    localparam logic [2:0] E_BAD_ACC  = 3'd1;
    localparam logic [2:0] E_BAD_PIN  = 3'd2;
    localparam logic [2:0] E_LOCKED   = 3'd3;
    localparam logic [2:0] E_INSUFF   = 3'd4;
    localparam logic [2:0] E_SAME_PIN = 3'd5;
    localparam logic [2:0] E_BAD_OP   = 3'd6;
    localparam logic [2:0] E_OVERFLOW = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHK_ACC = 3'd1,
        S_CHK_PIN = 3'd2,
        S_EXEC    = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [2:0]       op_q;
    logic [ACC_W-1:0] acc_q;
    logic [PIN_W-1:0] pin_q, npin_q;
    logic [AMT_W-1:0] amt_q;
    logic [2:0]       err_q;
    logic             ver_q;

    logic [BAL_W-1:0] bal_mem  [0:NUM_ACC];
    logic [PIN_W-1:0] pin_mem  [0:NUM_ACC];
    logic [CNT_W-1:0] fail_mem [0:NUM_ACC];
    logic             lock_mem [0:NUM_ACC];

    logic             done_q, success_q, locked_q;
    logic [2:0]       err_code_q;
    logic [BAL_W-1:0] balance_q;

    // Out-of-range account numbers are redirected to the unused slot 0.
    logic             w_acc_ok;
    logic [ACC_W-1:0] w_idx;
    logic [BAL_W-1:0] w_bal_cur;
    logic [BAL_W-1:0] w_amt_ext;
    logic [BAL_W:0]   w_sum;
    logic [CNT_W-1:0] w_fail_inc;

    assign w_acc_ok   = (acc_q != '0) && (int'(acc_q) <= NUM_ACC);
    assign w_idx      = w_acc_ok ? acc_q : '0;
    assign w_bal_cur  = bal_mem[w_idx];
    assign w_amt_ext  = BAL_W'(amt_q);
    assign w_sum      = {1'b0, w_bal_cur} + {1'b0, w_amt_ext};
    assign w_fail_inc = fail_mem[w_idx] + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:    state_d = start ? S_CHK_ACC : S_IDLE;
            S_CHK_ACC: state_d = S_CHK_PIN;
            S_CHK_PIN: state_d = S_EXEC;
            S_EXEC:    state_d = S_DONE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Every request walks all stages; a latched error turns the later stages
    // into pass-through cycles so latency never depends on the outcome.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= '0;
            acc_q      <= '0;
            pin_q      <= '0;
            npin_q     <= '0;
            amt_q      <= '0;
            err_q      <= E_OK;
            ver_q      <= 1'b0;
            done_q     <= 1'b0;
            success_q  <= 1'b0;
            locked_q   <= 1'b0;
            err_code_q <= E_OK;
            balance_q  <= '0;
            for (int k = 0; k <= NUM_ACC; k++) begin
                bal_mem[k]  <= BAL_W'(INIT_BAL);
                pin_mem[k]  <= PIN_W'(INIT_PIN + k);
                fail_mem[k] <= '0;
                lock_mem[k] <= 1'b0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= operation;
                        acc_q  <= acc_num;
                        pin_q  <= pin;
                        npin_q <= new_pin;
                        amt_q  <= amount;
                        err_q  <= E_OK;
                        ver_q  <= 1'b0;
                    end
                end
                S_CHK_ACC: begin
                    if (!w_acc_ok) err_q <= E_BAD_ACC;
                end
                S_CHK_PIN: begin
                    if (err_q == E_OK) begin
                        if (lock_mem[w_idx]) begin
                            err_q <= E_LOCKED;
                        end else if (pin_q != pin_mem[w_idx]) begin
                            fail_mem[w_idx] <= w_fail_inc;
                            if (w_fail_inc == CNT_W'(MAX_TRIES)) lock_mem[w_idx] <= 1'b1;
                            err_q <= E_BAD_PIN;
                        end else begin
                            fail_mem[w_idx] <= '0;
                            ver_q           <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    if (err_q == E_OK) begin
                        case (op_q)
                            3'd3: ;
                            3'd4: begin
                                if (w_amt_ext > w_bal_cur) err_q <= E_INSUFF;
                                else bal_mem[w_idx] <= w_bal_cur - w_amt_ext;
                            end
                            3'd5: begin
                                if (w_sum[BAL_W]) err_q <= E_OVERFLOW;
                                else bal_mem[w_idx] <= w_sum[BAL_W-1:0];
                            end
                            3'd6: begin
                                if (npin_q == pin_mem[w_idx]) err_q <= E_SAME_PIN;
                                else pin_mem[w_idx] <= npin_q;
                            end
                            default: err_q <= E_BAD_OP;
                        endcase
                    end
                end
                S_DONE: begin
                    done_q     <= 1'b1;
                    success_q  <= (err_q == E_OK);
                    err_code_q <= err_q;
                    balance_q  <= ver_q ? w_bal_cur : '0;
                    locked_q   <= w_acc_ok && lock_mem[w_idx];
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign success  = success_q;
    assign err_code = err_code_q;
    assign balance  = balance_q;
    assign locked   = locked_q;
    assign state    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_atm_multi_account.sv
// ==========================================================================
// Module   : tb_atm_multi_account
// Purpose  : Self-checking bench: default instance (u=0) and a 16-bit balance
//            instance (u=1), both against an account-level reference model.
// Revision : 1.0 - initial release
// ==========================================================================
`default_nettype none

module tb_atm_multi_account;

    logic        clk = 1'b0;
    logic        rst_a, rst_b, start_a, start_b;
    logic [2:0]  op;
    logic [3:0]  acc;
    logic [13:0] pin, npin;
    logic [15:0] amt;

    logic        busy_a, done_a, succ_a, lock_a;
    logic [2:0]  err_a, st_a;
    logic [31:0] bal_a;
    logic        busy_b, done_b, succ_b, lock_b;
    logic [2:0]  err_b, st_b;
    logic [15:0] bal_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    atm_multi_account dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .operation(op), .acc_num(acc),
        .pin(pin), .new_pin(npin), .amount(amt), .busy(busy_a), .done(done_a),
        .success(succ_a), .err_code(err_a), .balance(bal_a), .locked(lock_a),
        .state(st_a)
    );

    atm_multi_account #(.BAL_W(16), .INIT_BAL(65000)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .operation(op), .acc_num(acc),
        .pin(pin), .new_pin(npin), .amount(amt), .busy(busy_b), .done(done_b),
        .success(succ_b), .err_code(err_b), .balance(bal_b), .locked(lock_b),
        .state(st_b)
    );

    // Reference model: one record per account per instance.
    longint m_bal  [2][16];
    int     m_pin  [2][16];
    int     m_fail [2][16];
    bit     m_lock [2][16];
    longint m_init [2] = '{5000, 65000};
    longint m_max  [2] = '{64'hFFFF_FFFF, 64'hFFFF};

    function automatic void model_reset(input int u);
        for (int k = 0; k < 16; k++) begin
            m_bal[u][k]  = m_init[u];
            m_pin[u][k]  = 1000 + k;
            m_fail[u][k] = 0;
            m_lock[u][k] = 1'b0;
        end
    endfunction

    function automatic void model(input int u, input int o, input int a, input int p,
                                  input int np, input longint am,
                                  output int e, output longint b, output bit lk);
        e = 0; b = 0; lk = 1'b0;
        if (a == 0 || a > 10) begin
            e = 1;
        end else if (m_lock[u][a]) begin
            e = 3; lk = 1'b1;
        end else if (p != m_pin[u][a]) begin
            m_fail[u][a]++;
            if (m_fail[u][a] >= 3) m_lock[u][a] = 1'b1;
            e = 2; lk = m_lock[u][a];
        end else begin
            m_fail[u][a] = 0;
            case (o)
                3: ;
                4: if (am > m_bal[u][a]) e = 4; else m_bal[u][a] -= am;
                5: if (m_bal[u][a] + am > m_max[u]) e = 7; else m_bal[u][a] += am;
                6: if (np == m_pin[u][a]) e = 5; else m_pin[u][a] = np;
                default: e = 6;
            endcase
            b = m_bal[u][a];
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic req(input int u, input int o, input int a, input int p, input int np,
                       input longint am, input string tag);
        int lat;
        int e;
        longint b;
        bit lk;
        @(negedge clk);
        op = 3'(o); acc = 4'(a); pin = 14'(p); npin = 14'(np); amt = 16'(am);
        if (u == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        chk({tag, "/busy"}, (u == 0) ? busy_a : busy_b, 1);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if ((u == 0) ? done_a : done_b) break;
        end
        chk({tag, "/latency"}, lat, 4);
        model(u, o, a, p, np, am, e, b, lk);
        if (u == 0) begin
            chk({tag, "/err"}, err_a, e);
            chk({tag, "/success"}, succ_a, (e == 0));
            chk({tag, "/balance"}, bal_a, b);
            chk({tag, "/locked"}, lock_a, lk);
        end else begin
            chk({tag, "/err"}, err_b, e);
            chk({tag, "/success"}, succ_b, (e == 0));
            chk({tag, "/balance"}, bal_b, b);
            chk({tag, "/locked"}, lock_b, lk);
        end
    endtask

    initial begin
        int n, o, a, p, np;
        longint am;
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        op = '0; acc = '0; pin = '0; npin = '0; amt = '0;
        model_reset(0); model_reset(1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst/state", st_a, 0);
        chk("rst/busy", busy_a, 0);
        chk("rst/done", done_a, 0);
        chk("rst/success", succ_a, 0);
        chk("rst/err", err_a, 0);
        chk("rst/balance", bal_a, 0);
        chk("rst/locked", lock_a, 0);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        for (int k = 1; k <= 10; k++) req(0, 3, k, 1000 + k, 0, 0, "enq");

        req(0, 4, 1, 1001, 0, 6000, "wd6000");
        req(0, 5, 1, 1001, 0, 1000, "dep1000");
        req(0, 4, 1, 1001, 0, 500, "wd500");
        req(0, 4, 1, 1001, 0, 0, "wd0");

        req(0, 3, 0, 1000, 0, 0, "acc0");
        for (int k = 11; k <= 15; k++) req(0, 3, k, 1000, 0, 0, "accbig");
        req(0, 7, 2, 1002, 0, 0, "badop");

        for (int k = 0; k < 3; k++) req(0, 3, 3, 1234, 0, 0, "a3wrong");
        req(0, 3, 3, 1003, 0, 0, "a3locked");
        req(0, 3, 4, 1004, 0, 0, "a4ok");
        @(negedge clk); rst_a = 1'b1;
        @(negedge clk); rst_a = 1'b0;
        model_reset(0);
        req(0, 3, 3, 1003, 0, 0, "a3after_rst");

        req(0, 6, 5, 1005, 1005, 0, "samepin");
        req(0, 6, 5, 1005, 7123, 0, "chgpin");
        req(0, 3, 5, 1005, 0, 0, "oldpin");
        req(0, 3, 5, 7123, 0, 0, "newpin");
        req(0, 3, 6, 1, 0, 0, "a6w1");
        req(0, 3, 6, 2, 0, 0, "a6w2");
        req(0, 3, 6, 1006, 0, 0, "a6ok");
        req(0, 3, 6, 3, 0, 0, "a6w3");
        req(0, 3, 6, 4, 0, 0, "a6w4");
        req(0, 3, 6, 1006, 0, 0, "a6notlocked");

        req(1, 5, 1, 1001, 0, 600, "ovf600");
        req(1, 5, 1, 1001, 0, 535, "dep_to_max");

        @(negedge clk);
        op = 3'd4; acc = 4'd2; pin = 14'd1002; amt = 16'd100; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        @(posedge clk); #1;
        chk("midrst/pre_state", st_b, 2);
        rst_b = 1'b1;
        #1;
        chk("midrst/state", st_b, 0);
        chk("midrst/busy", busy_b, 0);
        chk("midrst/done", done_b, 0);
        chk("midrst/err", err_b, 0);
        chk("midrst/balance", bal_b, 0);
        chk("midrst/success", succ_b, 0);
        @(negedge clk); rst_b = 1'b0;
        model_reset(1);
        req(1, 3, 2, 1002, 0, 0, "midrst/bal_kept");

        @(negedge clk);
        op = 3'd3; acc = 4'd1; pin = 14'd1001; start_b = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        start_b = 1'b0;
        n = done_b ? 1 : 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done_b) n++;
        end
        chk("hold_start/dones", n, 1);

        for (int i = 0; i < 60; i++) begin
            int u;
            u  = (i < 40) ? 0 : 1;
            o  = $urandom_range(0, 7);
            a  = $urandom_range(0, 15);
            p  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 16383)
                                             : ((a >= 1 && a <= 10) ? m_pin[u][a] : 1000);
            np = ($urandom_range(0, 3) == 0 && a >= 1 && a <= 10) ? m_pin[u][a]
                                                                   : $urandom_range(0, 16383);
            am = ($urandom_range(0, 1) == 0) ? longint'($urandom_range(0, 65535))
                                             : longint'($urandom_range(0, 3000));
            req(u, o, a, p, np, am, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
